iob_cache_req_queue: RTL and testbench
======================================

Name: iob_cache_req_queue

Overview:
- Request queue and response buffer directly upstream of the cache front end's IOb slave port.
- Accepts valid/ready requests from an accelerator engine and buffers up to DEPTH of them.
- Issues them one at a time on the IOb handshake, and returns read data in order with backpressure.
- Uses read-credit flow control so that every issued read has a guaranteed response slot.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width (multiple of 8).
- DEPTH, 4, entries in the request FIFO and in the response FIFO (power of 2, ≥2).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_addr_i  in  ADDR_W  request address.
- req_wdata_i  in  DATA_W  write data.
- req_wstrb_i  in  DATA_W/8  byte strobes; all-zero = read.
- req_acache_i  in  4  cache attributes.
- resp_valid_o  out  1  read data available.
- resp_ready_i  in  1  consumer takes read data.
- resp_rdata_o  out  DATA_W  read data.
- iob_avalid_o  out  1  IOb request valid.
- iob_addr_o  out  ADDR_W  IOb address.
- iob_wdata_o  out  DATA_W  IOb write data.
- iob_wstrb_o  out  DATA_W/8  IOb strobes.
- iob_acache_o  out  4  IOb attributes.
- iob_ready_i  in  1  IOb request accepted.
- iob_rvalid_i  in  1  IOb read data valid.
- iob_rdata_i  in  DATA_W  IOb read data.
- rd_outstanding_o  out  $clog2(DEPTH)+1  reads issued, not yet returned.
- idle_o  out  1  both FIFOs empty and no reads outstanding.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - All pointers, counts, rd_outstanding_o and err_o go to 0.
  - req_ready_o=1, resp_valid_o=0, iob_avalid_o=0, idle_o=1.
  - All data outputs are 0.
  - Reset mid-operation discards queued requests and buffered responses without further IOb traffic. The integrator resets the cache in the same cycle.
- Request FIFO:
  - Push on req_valid_i & req_ready_o.
  - req_ready_o = (req_count < DEPTH). There is no full-bypass, so at full a simultaneous pop does not allow a push that cycle.
  - Stored entry is {addr, wdata, wstrb, acache}. The is_write bit is derived as |wstrb.
- Issue:
  - The head entry is driven onto the iob_* fields straight from the FIFO; fields are zero when empty.
  - Earliest iob_avalid_o is one cycle after the push; there is no combinational req→iob path.
  - credit_ok = (rd_outstanding + resp_count) < DEPTH.
  - iob_avalid_o = !req_empty & (is_write | credit_ok).
  - Pop on iob_avalid_o & iob_ready_i.
  - Once iob_avalid_o is asserted it remains asserted with stable fields until accepted. This holds because credit only grows while the head waits.
- Outstanding reads:
  - rd_outstanding increments on acceptance of a read, decrements on iob_rvalid_i, and is unchanged when both occur in the same cycle.
  - Writes produce no response and no count.
- Response FIFO:
  - Push iob_rdata_i on iob_rvalid_i. Credit guarantees it never overflows.
  - resp_valid_o = !resp_empty; first-word fall-through, resp_rdata_o is the head.
  - Pop on resp_valid_o & resp_ready_i.
  - Push and pop in the same cycle are both honoured.
  - Earliest resp_valid_o is one cycle after iob_rvalid_i.
  - Responses are returned strictly in request order.
- Errors:
  - iob_rvalid_i while rd_outstanding==0 sets err_o (sticky until reset) and the data is dropped.
  - An overflow attempt on the response FIFO likewise sets err_o and drops the data.
- Pointers:
  - Pointers are $clog2(DEPTH) bits and wrap naturally.
  - Counts are $clog2(DEPTH)+1 bits and saturate at neither end because the handshakes prevent it.
- idle_o = req_empty & resp_empty & (rd_outstanding==0); combinational from registered state.

Test Plan:
- Single read: push addr 0x100, wstrb 0; IOb ready=1, rvalid 2 cycles after accept with 0xDEADBEEF.
  - Expect iob_avalid_o 1 cycle after push.
  - Expect rd_outstanding_o 1→0.
  - Expect resp_valid_o with 0xDEADBEEF one cycle after rvalid; idle_o=1 after pop.
- Write: push addr 0x40, wdata 0x12345678, wstrb 0xF; ready=1.
  - Expect one IOb beat carrying those values.
  - Expect rd_outstanding_o to stay 0 and no resp_valid_o.
- Full/backpressure: IOb ready=0, push 5 requests.
  - Expect req_ready_o=0 after the 4th push and the 5th held.
  - Raise ready: 4 beats issue in order and req_ready_o returns 1 the cycle after the first pop.
- Credit stall: resp_ready_i=0, 6 reads with rvalid one cycle after each accept.
  - Expect exactly 4 reads issued, then iob_avalid_o=0.
  - Release resp_ready_i: each pop frees one issue; data order preserved.
- Mixed/simultaneous: alternating read/write stream with push and pop in the same cycle at count 2, plus rvalid coinciding with a new read accept.
  - Expect counts unchanged across those cycles and response order matching read order.
- Error/reset: assert iob_rvalid_i with nothing outstanding → err_o=1 and no resp_valid_o.
  - Reset mid-stream with 3 queued → all outputs return to reset values next cycle and err_o clears.

Source files
------------

// File: rtl/iob_cache_req_queue.sv
// Request queue and in-order response buffer in front of the cache IOb slave port.
// Requests are buffered in a small FIFO and issued one at a time on the IOb
// handshake. Reads are only issued while a response slot is guaranteed, which is
// tracked by the outstanding-read count plus the response FIFO occupancy.
module iob_cache_req_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       req_valid_i,
    output logic                       req_ready_o,
    input  logic [ADDR_W-1:0]          req_addr_i,
    input  logic [DATA_W-1:0]          req_wdata_i,
    input  logic [DATA_W/8-1:0]        req_wstrb_i,
    input  logic [3:0]                 req_acache_i,
    output logic                       resp_valid_o,
    input  logic                       resp_ready_i,
    output logic [DATA_W-1:0]          resp_rdata_o,
    output logic                       iob_avalid_o,
    output logic [ADDR_W-1:0]          iob_addr_o,
    output logic [DATA_W-1:0]          iob_wdata_o,
    output logic [DATA_W/8-1:0]        iob_wstrb_o,
    output logic [3:0]                 iob_acache_o,
    input  logic                       iob_ready_i,
    input  logic                       iob_rvalid_i,
    input  logic [DATA_W-1:0]          iob_rdata_i,
    output logic [$clog2(DEPTH):0]     rd_outstanding_o,
    output logic                       idle_o,
    output logic                       err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = DATA_W / 8;
    // Entry layout: {addr, wdata, wstrb, acache}
    localparam int EW      = ADDR_W + DATA_W + SW + 4;
    localparam int WSTRB_L = 4;
    localparam int WDATA_L = 4 + SW;
    localparam int ADDR_L  = 4 + SW + DATA_W;

    logic [EW-1:0]     req_mem [DEPTH];
    logic [DATA_W-1:0] resp_mem [DEPTH];

    logic [PW-1:0] req_wr_ptr_q, req_wr_ptr_d;
    logic [PW-1:0] req_rd_ptr_q, req_rd_ptr_d;
    logic [CW-1:0] req_count_q, req_count_d;
    logic [PW-1:0] resp_wr_ptr_q, resp_wr_ptr_d;
    logic [PW-1:0] resp_rd_ptr_q, resp_rd_ptr_d;
    logic [CW-1:0] resp_count_q, resp_count_d;
    logic [CW-1:0] rd_out_q, rd_out_d;
    logic          err_q, err_d;

    logic          req_empty;
    logic          resp_empty;
    logic          resp_full;
    logic [EW-1:0] req_entry_in;
    logic [EW-1:0] head;
    logic          head_is_write;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          req_push;
    logic          req_pop;
    logic          rd_issue;
    logic          rsp_expected;
    logic          resp_push;
    logic          resp_pop;
    logic          rsp_err;

    // Status, head-of-queue decode and handshake qualifiers
    always_comb begin
        req_empty     = (req_count_q == '0);
        resp_empty    = (resp_count_q == '0);
        resp_full     = (resp_count_q == CW'(DEPTH));
        req_entry_in  = {req_addr_i, req_wdata_i, req_wstrb_i, req_acache_i};
        head          = req_mem[req_rd_ptr_q];
        head_is_write = |head[WDATA_L-1:WSTRB_L];
        // A read may only go out if a response slot is already reserved for it
        credit_sum    = {1'b0, rd_out_q} + {1'b0, resp_count_q};
        credit_ok     = (credit_sum < (CW+1)'(DEPTH));

        req_ready_o   = (req_count_q < CW'(DEPTH));
        iob_avalid_o  = !req_empty && (head_is_write || credit_ok);
        iob_addr_o    = req_empty ? '0 : head[EW-1:ADDR_L];
        iob_wdata_o   = req_empty ? '0 : head[ADDR_L-1:WDATA_L];
        iob_wstrb_o   = req_empty ? '0 : head[WDATA_L-1:WSTRB_L];
        iob_acache_o  = req_empty ? '0 : head[WSTRB_L-1:0];

        resp_valid_o  = !resp_empty;
        resp_rdata_o  = resp_empty ? '0 : resp_mem[resp_rd_ptr_q];

        req_push      = req_valid_i && req_ready_o;
        req_pop       = iob_avalid_o && iob_ready_i;
        rd_issue      = req_pop && !head_is_write;
        // Unsolicited or overflowing read data is dropped and flagged
        rsp_expected  = iob_rvalid_i && (rd_out_q != '0);
        resp_push     = rsp_expected && !resp_full;
        resp_pop      = resp_valid_o && resp_ready_i;
        rsp_err       = iob_rvalid_i && ((rd_out_q == '0) || resp_full);

        rd_outstanding_o = rd_out_q;
        idle_o           = req_empty && resp_empty && (rd_out_q == '0);
        err_o            = err_q;
    end

    // Next-state computation for pointers, counts and the error flag
    always_comb begin
        req_wr_ptr_d  = req_wr_ptr_q  + PW'(req_push);
        req_rd_ptr_d  = req_rd_ptr_q  + PW'(req_pop);
        req_count_d   = req_count_q   + CW'(req_push)  - CW'(req_pop);
        resp_wr_ptr_d = resp_wr_ptr_q + PW'(resp_push);
        resp_rd_ptr_d = resp_rd_ptr_q + PW'(resp_pop);
        resp_count_d  = resp_count_q  + CW'(resp_push) - CW'(resp_pop);
        rd_out_d      = rd_out_q      + CW'(rd_issue)  - CW'(rsp_expected);
        err_d         = err_q || rsp_err;
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_wr_ptr_q  <= '0;
            req_rd_ptr_q  <= '0;
            req_count_q   <= '0;
            resp_wr_ptr_q <= '0;
            resp_rd_ptr_q <= '0;
            resp_count_q  <= '0;
            rd_out_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            req_wr_ptr_q  <= req_wr_ptr_d;
            req_rd_ptr_q  <= req_rd_ptr_d;
            req_count_q   <= req_count_d;
            resp_wr_ptr_q <= resp_wr_ptr_d;
            resp_rd_ptr_q <= resp_rd_ptr_d;
            resp_count_q  <= resp_count_d;
            rd_out_q      <= rd_out_d;
            err_q         <= err_d;
        end
    end

    // Storage entries; contents are only visible through the empty-gated outputs
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        // Capture a new request into its slot
        always_ff @(posedge clk_i) begin
            if (req_push && (req_wr_ptr_q == PW'(gi))) begin
                req_mem[gi] <= req_entry_in;
            end
        end

        // Capture returning read data into its slot
        always_ff @(posedge clk_i) begin
            if (resp_push && (resp_wr_ptr_q == PW'(gi))) begin
                resp_mem[gi] <= iob_rdata_i;
            end
        end
    end

endmodule

// File: tb/tb_iob_cache_req_queue.sv
// Bench for iob_cache_req_queue: queue-based reference model checked every cycle,
// an IOb responder with programmable read latency, and directed scenarios.
module tb_iob_cache_req_queue;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int D  = 4;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic [AW-1:0] req_addr_i;
    logic [DW-1:0] req_wdata_i;
    logic [SW-1:0] req_wstrb_i;
    logic [3:0]    req_acache_i;
    logic          resp_valid_o;
    logic          resp_ready_i;
    logic [DW-1:0] resp_rdata_o;
    logic          iob_avalid_o;
    logic [AW-1:0] iob_addr_o;
    logic [DW-1:0] iob_wdata_o;
    logic [SW-1:0] iob_wstrb_o;
    logic [3:0]    iob_acache_o;
    logic          iob_ready_i;
    logic          iob_rvalid_i;
    logic [DW-1:0] iob_rdata_i;
    logic [$clog2(D):0] rd_outstanding_o;
    logic          idle_o;
    logic          err_o;

    always #5 clk = ~clk;

    iob_cache_req_queue #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .req_wstrb_i(req_wstrb_i), .req_acache_i(req_acache_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o),
        .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o),
        .iob_wdata_o(iob_wdata_o), .iob_wstrb_o(iob_wstrb_o),
        .iob_acache_o(iob_acache_o), .iob_ready_i(iob_ready_i),
        .iob_rvalid_i(iob_rvalid_i), .iob_rdata_i(iob_rdata_i),
        .rd_outstanding_o(rd_outstanding_o), .idle_o(idle_o), .err_o(err_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory behind the IOb port
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [3:0]    acache;
    } req_t;

    req_t          m_req[$];
    logic [DW-1:0] m_resp[$];
    logic [AW-1:0] m_rd_addr[$];   // reads accepted by IOb and awaiting data, in order
    bit            m_err  = 1'b0;
    bit            chk_en = 1'b0;

    initial begin
        forever begin
            bit            e_rr, e_av, e_rv, e_idle;
            logic [AW-1:0] e_addr;
            logic [DW-1:0] e_wdata, e_rd;
            logic [SW-1:0] e_wstrb;
            logic [3:0]    e_ac;
            int            outst;
            @(negedge clk);
            outst  = m_rd_addr.size();
            e_rr   = (m_req.size() < D);
            e_av   = (m_req.size() > 0) && ((m_req[0].wstrb != 0) || (outst + m_resp.size() < D));
            e_addr  = (m_req.size() > 0) ? m_req[0].addr   : '0;
            e_wdata = (m_req.size() > 0) ? m_req[0].wdata  : '0;
            e_wstrb = (m_req.size() > 0) ? m_req[0].wstrb  : '0;
            e_ac    = (m_req.size() > 0) ? m_req[0].acache : '0;
            e_rv   = (m_resp.size() > 0);
            e_rd   = e_rv ? m_resp[0] : '0;
            e_idle = (m_req.size() == 0) && (m_resp.size() == 0) && (outst == 0);
            if (chk_en) begin
                check("req_ready", req_ready_o, e_rr);
                check("iob_avalid", iob_avalid_o, e_av);
                check("iob_addr", iob_addr_o, e_addr);
                check("iob_wdata", iob_wdata_o, e_wdata);
                check("iob_wstrb", iob_wstrb_o, e_wstrb);
                check("iob_acache", iob_acache_o, e_ac);
                check("resp_valid", resp_valid_o, e_rv);
                check("resp_rdata", resp_rdata_o, e_rd);
                check("rd_outstanding", rd_outstanding_o, outst);
                check("idle", idle_o, e_idle);
                check("err", err_o, m_err);
            end
            // Advance the model by the clock edge that will sample the current inputs
            if (rst_i) begin
                m_req.delete();
                m_resp.delete();
                m_rd_addr.delete();
                m_err  = 1'b0;
                chk_en = 1'b1;
            end else if (chk_en) begin
                bit rv_ok, full_now;
                full_now = (m_resp.size() == D);
                rv_ok    = iob_rvalid_i && (outst > 0);
                if (iob_rvalid_i && (outst == 0 || full_now)) m_err = 1'b1;
                if (e_rv && resp_ready_i) void'(m_resp.pop_front());
                if (rv_ok) begin
                    logic [AW-1:0] a;
                    a = m_rd_addr.pop_front();
                    if (!full_now) m_resp.push_back(mem_data(a));
                end
                if (e_av && iob_ready_i) begin
                    if (m_req[0].wstrb == 0) m_rd_addr.push_back(m_req[0].addr);
                    void'(m_req.pop_front());
                end
                if (e_rr && req_valid_i) begin
                    req_t r;
                    r.addr = req_addr_i; r.wdata = req_wdata_i;
                    r.wstrb = req_wstrb_i; r.acache = req_acache_i;
                    m_req.push_back(r);
                end
            end
        end
    end

    // ---------------- IOb responder ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } pend_t;

    pend_t pend[$];
    int    cyc    = 0;
    int    lat    = 1;
    bit    inject = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_i) pend.delete();
            else if (iob_avalid_o && iob_ready_i && iob_wstrb_o == 0)
                pend.push_back('{cyc + lat, mem_data(iob_addr_o)});
        end
    end

    initial begin
        iob_rvalid_i = 1'b0;
        iob_rdata_i  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (inject) begin
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = 32'hBAD0BAD0;
                inject       = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                pend_t p;
                p = pend.pop_front();
                iob_rvalid_i = 1'b1;
                iob_rdata_i  = p.d;
            end else begin
                iob_rvalid_i = 1'b0;
                iob_rdata_i  = '0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_off();
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_wstrb_i  = '0;
        req_acache_i = '0;
    endtask

    // Present a request and hold it until accepted; returns just after the accepting edge
    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] w,
                        input logic [SW-1:0] s, input logic [3:0] c);
        bit acc;
        int t;
        req_valid_i = 1'b1; req_addr_i = a; req_wdata_i = w;
        req_wstrb_i = s; req_acache_i = c;
        t = 0;
        do begin
            acc = req_ready_o;
            tick();
            t++;
        end while (!acc && t < 100);
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL push_timeout: addr 0x%0h not accepted after %0d cycles", a, t);
        end
        $display("push addr=0x%0h wdata=0x%0h wstrb=0x%0h acache=0x%0h", a, w, s, c);
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while (!(idle_o && pend.size() == 0 && !iob_rvalid_i) && t < 300) begin
            tick();
            t++;
        end
        n_checks++;
        if (t >= 300) begin
            n_fail++;
            $display("FAIL %s: idle not reached within %0d cycles", name, t);
        end
    endtask

    initial begin
        rst_i = 1'b1; resp_ready_i = 1'b0; iob_ready_i = 1'b0;
        req_off();
        repeat (3) tick();
        check("rst_req_ready", req_ready_o, 1);
        check("rst_avalid", iob_avalid_o, 0);
        check("rst_idle", idle_o, 1);
        rst_i = 1'b0;
        tick();

        // Single read, data two cycles after accept
        lat = 2; iob_ready_i = 1'b1;
        push(32'h100, '0, '0, 4'h3);
        check("rd_avalid_after_push", iob_avalid_o, 1);
        check("rd_iob_addr", iob_addr_o, 32'h100);
        req_off();
        tick();
        check("rd_outstanding_1", rd_outstanding_o, 1);
        begin
            int t = 0;
            while (!resp_valid_o && t < 20) begin tick(); t++; end
        end
        check("rd_resp_valid", resp_valid_o, 1);
        check("rd_resp_data", resp_rdata_o, 32'hDEADBEEF);
        check("rd_outstanding_0", rd_outstanding_o, 0);
        resp_ready_i = 1'b1;
        tick();
        resp_ready_i = 1'b0;
        check("rd_idle_after_pop", idle_o, 1);
        $display("single read done");

        // Write: one beat, no response
        push(32'h40, 32'h12345678, 4'hF, 4'h0);
        check("wr_avalid", iob_avalid_o, 1);
        check("wr_wdata", iob_wdata_o, 32'h12345678);
        check("wr_wstrb", iob_wstrb_o, 4'hF);
        req_off();
        tick(); tick();
        check("wr_outstanding", rd_outstanding_o, 0);
        check("wr_no_resp", resp_valid_o, 0);
        $display("write done");

        // Full / backpressure
        lat = 1; iob_ready_i = 1'b0; resp_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) push(32'h200 + 32'(i * 4), '0, '0, 4'(i));
        check("full_ready_low", req_ready_o, 0);
        req_valid_i = 1'b1; req_addr_i = 32'h210; req_wdata_i = '0;
        req_wstrb_i = '0; req_acache_i = 4'h4;
        tick(); tick();
        check("full_still_low", req_ready_o, 0);
        check("full_head_held", iob_addr_o, 32'h200);
        iob_ready_i = 1'b1;
        tick();
        check("full_ready_back", req_ready_o, 1);
        tick();
        req_off();
        wait_idle("full_drain");
        $display("backpressure done");

        // Credit stall with consumer blocked
        resp_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) push(32'h300 + 32'(i * 4), '0, '0, 4'(i));
        req_off();
        repeat (5) tick();
        check("credit_avalid_low", iob_avalid_o, 0);
        check("credit_outstanding", rd_outstanding_o, 0);
        check("credit_resp_head", resp_rdata_o, mem_data(32'h300));
        resp_ready_i = 1'b1;
        wait_idle("credit_drain");
        $display("credit stall done");

        // Mixed read/write stream with varying ready on both sides
        begin
            int k = 0;
            for (int c = 0; c < 40; c++) begin
                bit acc;
                req_valid_i  = (k < 10);
                req_addr_i   = 32'h400 + 32'(k * 4);
                req_wdata_i  = 32'hA000_0000 + 32'(k);
                req_wstrb_i  = k[0] ? 4'hF : 4'h0;
                req_acache_i = 4'(k);
                iob_ready_i  = (c % 5 != 2);
                resp_ready_i = (c % 3 != 0);
                acc = req_valid_i && req_ready_o;
                tick();
                if (acc) k++;
            end
            $display("mixed stream pushed %0d requests", k);
        end
        req_off();
        iob_ready_i = 1'b1; resp_ready_i = 1'b1;
        wait_idle("mixed_drain");

        // Unsolicited read data
        inject = 1'b1;
        repeat (3) tick();
        check("err_set", err_o, 1);
        check("err_no_resp", resp_valid_o, 0);
        $display("error injection done");

        // Reset mid-stream
        iob_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) push(32'h500 + 32'(i * 4), '0, '0, 4'h1);
        req_off();
        check("pre_reset_busy", idle_o, 0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_avalid", iob_avalid_o, 0);
        check("mid_rst_addr", iob_addr_o, 0);
        check("mid_rst_idle", idle_o, 1);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_ready", req_ready_o, 1);
        repeat (3) tick();
        $display("reset mid-stream done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
